arc4_encrypt: RTL and testbench

- Standalone ARC4 encryptor: reads a length-prefixed plaintext from a pt memory port and writes the length-prefixed ciphertext to a ct memory port.
- Runs init, KSA and PRGA in one FSM, driving an external 256x8 S memory.
- Produces the ciphertext messages that the crack/decrypt path consumes; used for on-chip test-vector generation.

---
 rtl/arc4_encrypt.sv | 200 ++++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: len-prefixed pt memory -> len-prefixed ct memory via external 256x8 S memory; en/rdy start handshake,
// ~1795+8*len cycles en->rdy, en ignored while busy. Optional plaintext range flag pt_err under `ARC4_ENCRYPT_PT_CHECK_EN.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
  ,
  output logic                   pt_err
`endif
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(KEY_BYTES - 1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_LEN_RD   = 4'd1;
  localparam logic [3:0] ST_LEN_WAIT = 4'd2;
  localparam logic [3:0] ST_INIT     = 4'd3;
  localparam logic [3:0] ST_RDI      = 4'd4;
  localparam logic [3:0] ST_GETI     = 4'd5;
  localparam logic [3:0] ST_RDJ      = 4'd6;
  localparam logic [3:0] ST_GETJ     = 4'd7;
  localparam logic [3:0] ST_WRI      = 4'd8;
  localparam logic [3:0] ST_WRJ      = 4'd9;
  localparam logic [3:0] ST_RDP      = 4'd10;
  localparam logic [3:0] ST_GETP     = 4'd11;
  localparam logic [3:0] ST_DONE     = 4'd12;

  logic [3:0]    state;
  logic          prga;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [7:0]    len;
  logic [7:0]    k;
  logic [7:0]    ptb;
  logic [KW-1:0] kidx;
  logic [7:0]    key_byte;
  logic [7:0]    j_next;

  always_comb begin
    key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kidx == KW'(n)) key_byte = key[8*(KEY_BYTES-1-n) +: 8];
    end
  end

  // KSA and PRGA share the read/swap states; only the key term differs.
  assign j_next = j + s_rddata + (prga ? 8'h00 : key_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdy       <= 1'b1;
      prga      <= 1'b0;
      i         <= 8'h00;
      j         <= 8'h00;
      si        <= 8'h00;
      sj        <= 8'h00;
      len       <= 8'h00;
      k         <= 8'h00;
      ptb       <= 8'h00;
      kidx      <= '0;
      s_addr    <= 8'h00;
      s_wrdata  <= 8'h00;
      s_wren    <= 1'b0;
      pt_addr   <= 8'h00;
      ct_addr   <= 8'h00;
      ct_wrdata <= 8'h00;
      ct_wren   <= 1'b0;
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
      pt_err    <= 1'b0;
`endif
    end else begin
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            rdy     <= 1'b0;
            pt_addr <= 8'h00;
            state   <= ST_LEN_RD;
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
            pt_err  <= 1'b0;
`endif
          end
        end
        ST_LEN_RD: state <= ST_LEN_WAIT;
        ST_LEN_WAIT: begin
          len       <= pt_rddata;
          ct_addr   <= 8'h00;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          if (pt_rddata == 8'h00) begin
            state <= ST_DONE;
          end else begin
            s_addr   <= 8'h00;
            s_wrdata <= 8'h00;
            s_wren   <= 1'b1;
            state    <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (s_addr == 8'hFF) begin
            prga   <= 1'b0;
            i      <= 8'h00;
            j      <= 8'h00;
            kidx   <= '0;
            s_addr <= 8'h00;
            state  <= ST_RDI;
          end else begin
            s_addr   <= s_addr + 8'd1;
            s_wrdata <= s_addr + 8'd1;
            s_wren   <= 1'b1;
          end
        end
        ST_RDI: state <= ST_GETI;
        ST_GETI: begin
          si     <= s_rddata;
          j      <= j_next;
          s_addr <= j_next;
          state  <= ST_RDJ;
        end
        ST_RDJ: state <= ST_GETJ;
        ST_GETJ: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          if (prga) pt_addr <= k;
          state    <= ST_WRI;
        end
        ST_WRI: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= ST_WRJ;
        end
        ST_WRJ: begin
          if (prga) begin
            ptb    <= pt_rddata;
            s_addr <= si + sj;
            state  <= ST_RDP;
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
            if (pt_rddata < 8'h20 || pt_rddata > 8'h7E) pt_err <= 1'b1;
`endif
          end else if (i == 8'hFF) begin
            // KSA finished: PRGA starts with i already stepped to 1.
            prga   <= 1'b1;
            i      <= 8'h01;
            j      <= 8'h00;
            k      <= 8'h01;
            s_addr <= 8'h01;
            state  <= ST_RDI;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            kidx   <= (kidx == KLAST) ? '0 : kidx + KW'(1);
            state  <= ST_RDI;
          end
        end
        ST_RDP: state <= ST_GETP;
        ST_GETP: begin
          ct_addr   <= k;
          ct_wrdata <= s_rddata ^ ptb;
          ct_wren   <= 1'b1;
          if (k == len) begin
            state <= ST_DONE;
          end else begin
            k      <= k + 8'd1;
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            state  <= ST_RDI;
          end
        end
        ST_DONE: begin
          rdy   <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: known vectors, handshake/reset corner cases and random runs against an ARC4 model.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en [2];
  logic        rdy [2];
  logic [23:0] key3;
  logic [31:0] key4;
  logic [7:0]  s_addr [2], s_wrdata [2], s_rddata [2];
  logic        s_wren [2];
  logic [7:0]  pt_addr [2], pt_rddata [2];
  logic [7:0]  ct_addr [2], ct_wrdata [2];
  logic        ct_wren [2];
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
  logic        pt_err [2];
`endif

  always #5 clk = ~clk;

  arc4_encrypt #(.KEY_BYTES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key3),
    .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]), .s_rddata(s_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_rddata(pt_rddata[0]),
    .ct_addr(ct_addr[0]), .ct_wrdata(ct_wrdata[0]), .ct_wren(ct_wren[0])
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
    , .pt_err(pt_err[0])
`endif
  );

  arc4_encrypt #(.KEY_BYTES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key4),
    .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]), .s_rddata(s_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_rddata(pt_rddata[1]),
    .ct_addr(ct_addr[1]), .ct_wrdata(ct_wrdata[1]), .ct_wren(ct_wren[1])
`ifdef ARC4_ENCRYPT_PT_CHECK_EN
    , .pt_err(pt_err[1])
`endif
  );

  // Memories and activity counters, written only here.
  logic [7:0] s_mem [2][256];
  logic [7:0] pt_mem [2][256];
  logic [7:0] ct_mem [2][256];
  int         ct_tag [2][256];
  int         ct_gen [2];
  int         ct_cnt [2], s_cnt [2], rise_cnt [2], ord_err [2];
  logic       rdy_q [2];
  logic [7:0] last_ct [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_rddata[d]  <= s_mem[d][s_addr[d]];
      pt_rddata[d] <= pt_mem[d][pt_addr[d]];
      if (s_wren[d]) begin
        s_mem[d][s_addr[d]] <= s_wrdata[d];
        s_cnt[d] <= s_cnt[d] + 1;
      end
      if (ct_wren[d]) begin
        ct_mem[d][ct_addr[d]] <= ct_wrdata[d];
        ct_tag[d][ct_addr[d]] <= ct_gen[d];
        ct_cnt[d] <= ct_cnt[d] + 1;
        if (ct_addr[d] != 8'h00 && ct_addr[d] <= last_ct[d]) ord_err[d] <= ord_err[d] + 1;
        last_ct[d] <= ct_addr[d];
      end
      rdy_q[d] <= rdy[d];
      if (rdy[d] && !rdy_q[d]) rise_cnt[d] <= rise_cnt[d] + 1;
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         b_ct, b_s, b_rise, b_ord, lat;
  logic [7:0] exp_ct [256];

  typedef struct {
    int          dut;
    logic [31:0] key;
    int          nb;
    logic [79:0] pt;
    logic [79:0] ct;
  } vec_t;
  vec_t vt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain ARC4 over pt_mem[d] (byte 0 = length), result into exp_ct.
  task automatic model(input int d, input logic [31:0] k, input int klen);
    int S [256];
    int ii, jj, t, n;
    logic [7:0] kb;
    for (int x = 0; x < 256; x++) S[x] = x;
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      kb = 8'(k >> (8 * (klen - 1 - (x % klen))));
      jj = (jj + S[x] + int'(kb)) % 256;
      t = S[x]; S[x] = S[jj]; S[jj] = t;
    end
    n = int'(pt_mem[d][0]);
    exp_ct[0] = pt_mem[d][0];
    ii = 0; jj = 0;
    for (int x = 1; x <= n; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + S[ii]) % 256;
      t = S[ii]; S[ii] = S[jj]; S[jj] = t;
      exp_ct[x] = 8'(S[(S[ii] + S[jj]) % 256]) ^ pt_mem[d][x];
    end
  endtask

  task automatic start(input int d, input logic [31:0] k);
    if (d == 0) key3 = k[23:0];
    else key4 = k;
    ct_gen[d] = ct_gen[d] + 1;
    b_ct = ct_cnt[d]; b_s = s_cnt[d]; b_rise = rise_cnt[d]; b_ord = ord_err[d];
    @(negedge clk); en[d] = 1'b1;
    @(negedge clk); en[d] = 1'b0;
  endtask

  task automatic finish(input int d, input int budget, input string name);
    lat = 1;
    while (rdy[d] !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_rdy_timeout"}, 32'(rdy[d]), 32'd1);
    @(negedge clk);
  endtask

  task automatic verify(input int d, input string name);
    int n;
    n = int'(pt_mem[d][0]);
    for (int b = 0; b <= n; b++)
      chk($sformatf("%s_ct[%0d]", name, b),
          (ct_tag[d][b] == ct_gen[d]) ? 32'(ct_mem[d][b]) : 32'h100, 32'(exp_ct[b]));
    chk({name, "_ct_wren_pulses"}, 32'(ct_cnt[d] - b_ct), 32'(n + 1));
    chk({name, "_s_wren_pulses"}, 32'(s_cnt[d] - b_s), (n == 0) ? 32'd0 : 32'(768 + 2 * n));
    chk({name, "_rdy_rises"}, 32'(rise_cnt[d] - b_rise), 32'd1);
    chk({name, "_ct_order"}, 32'(ord_err[d] - b_ord), 32'd0);
    chk({name, "_latency_bound"}, 32'(lat <= 256 + 2048 + 10 * n + 8), 32'd1);
  endtask

  task automatic load_vec(input int v);
    for (int b = 0; b < vt[v].nb; b++) begin
      pt_mem[vt[v].dut][b] = vt[v].pt[8*(vt[v].nb-1-b) +: 8];
      exp_ct[b]            = vt[v].ct[8*(vt[v].nb-1-b) +: 8];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] rk;
    vt[0] = '{0, 32'h004B6579, 10, 80'({8'h09, "Plaintext"}), 80'h09BBF316E8D940AF0AD3};
    vt[1] = '{1, 32'h57696B69, 6, 80'({8'h05, "pedia"}), 80'h051021BF0420};
    vt[2] = '{0, 32'h00123456, 1, 80'h00, 80'h00};
    en[0] = 1'b0; en[1] = 1'b0; key3 = '0; key4 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdy%0d", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("reset_s_wren%0d", d), 32'(s_wren[d]), 32'd0);
      chk($sformatf("reset_ct_wren%0d", d), 32'(ct_wren[d]), 32'd0);
      chk($sformatf("reset_addrs%0d", d), {s_addr[d], pt_addr[d], ct_addr[d], ct_wrdata[d]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors.
    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      start(vt[v].dut, vt[v].key);
      finish(vt[v].dut, 4000, $sformatf("vec%0d", v));
      verify(vt[v].dut, $sformatf("vec%0d", v));
      if (vt[v].nb == 1) chk("len0_latency_le8", 32'(lat <= 8), 32'd1);
    end

    // Extra en during KSA is ignored; then a new key on the next run.
    load_vec(0);
    start(0, 32'h4B6579);
    repeat (600) @(negedge clk);
    en[0] = 1'b1; @(negedge clk); en[0] = 1'b0;
    finish(0, 4000, "ksa_en");
    verify(0, "ksa_en");
    model(0, 32'h00A1B2C3, 3);
    start(0, 32'h00A1B2C3);
    finish(0, 4000, "newkey");
    verify(0, "newkey");

    // Reset in the middle of PRGA aborts immediately.
    load_vec(0);
    start(0, 32'h4B6579);
    repeat (256 + 1536 + 2 + 20) @(negedge clk);
    b_ct = ct_cnt[0]; b_s = s_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(rdy[0]), 32'd1);
    chk("rst_mid_s_wren", 32'(s_wren[0]), 32'd0);
    chk("rst_mid_ct_wren", 32'(ct_wren[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_writes", 32'((ct_cnt[0] - b_ct) + (s_cnt[0] - b_s)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    model(0, 32'h4B6579, 3);
    start(0, 32'h4B6579);
    finish(0, 4000, "after_rst");
    verify(0, "after_rst");

    // Random keys and plaintexts, including the maximum length.
    for (int r = 0; r < 6; r++) begin
      n = (r == 5) ? 255 : int'($urandom_range(1, 30));
      rk = (r % 2 == 0) ? {8'h00, 24'($urandom)} : $urandom;
      pt_mem[r % 2][0] = 8'(n);
      for (int b = 1; b <= n; b++) pt_mem[r % 2][b] = 8'($urandom);
      model(r % 2, rk, (r % 2 == 0) ? 3 : 4);
      start(r % 2, rk);
      finish(r % 2, 6000, $sformatf("rand%0d", r));
      verify(r % 2, $sformatf("rand%0d", r));
    end

`ifdef ARC4_ENCRYPT_PT_CHECK_EN
    pt_mem[0][0] = 8'h03; pt_mem[0][1] = 8'h41; pt_mem[0][2] = 8'h0A; pt_mem[0][3] = 8'h42;
    model(0, 32'h4B6579, 3);
    start(0, 32'h4B6579);
    finish(0, 4000, "pterr_bad");
    verify(0, "pterr_bad");
    chk("pt_err_set", 32'(pt_err[0]), 32'd1);
    pt_mem[0][0] = 8'h02; pt_mem[0][1] = 8'h41; pt_mem[0][2] = 8'h42;
    model(0, 32'h4B6579, 3);
    start(0, 32'h4B6579);
    finish(0, 4000, "pterr_ok");
    verify(0, "pterr_ok");
    chk("pt_err_clear", 32'(pt_err[0]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
